// File: rtl/circuito3_reverse_lookup.sv
// Sequential reverse lookup for the CIRCUITO3 constant table: maps a data word back to the
// lowest address holding it, scanning one entry per clock behind valid/ready handshakes.
module circuito3_reverse_lookup #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_key
);

    localparam logic [ADDR_WIDTH-1:0] LastIdx = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic                  hit_q, hit_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Entries beyond the four defined words read as zero.
    function automatic logic [DATA_WIDTH-1:0] table_word(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        case (a)
            ADDR_WIDTH'(0): w = DATA_WIDTH'(3'b011);
            ADDR_WIDTH'(1): w = DATA_WIDTH'(3'b110);
            ADDR_WIDTH'(2): w = DATA_WIDTH'(3'b100);
            ADDR_WIDTH'(3): w = DATA_WIDTH'(3'b010);
            default:        w = '0;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            key_q   <= '0;
            hit_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            hit_q   <= hit_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        key_d   = key_q;
        hit_d   = hit_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    key_d   = req_data;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                // Ascending scan, so the lowest matching address wins.
                if (table_word(idx_q) == key_q) begin
                    hit_d   = 1'b1;
                    addr_d  = idx_q;
                    state_d = StResp;
                end else if (idx_q == LastIdx) begin
                    hit_d   = 1'b0;
                    addr_d  = '0;
                    state_d = StResp;
                end else begin
                    idx_d = idx_q + ADDR_WIDTH'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_hit   = hit_q;
    assign rsp_addr  = addr_q;
    assign rsp_key   = key_q;

endmodule

// File: doc/circuito3_reverse_lookup.md
# circuito3_reverse_lookup

Sequential reverse lookup for the CIRCUITO3 4-entry constant table. Given a 3-bit data word, the block scans the table one entry per clock and returns the 2-bit address that holds it, or a miss. It is the decode side of the table: CIRCUITO3 maps address to data, and this block maps data back to address. Requests and responses use valid/ready handshakes, so the block can sit between a producer and a consumer that may stall.

## Interface
Parameters:
- ADDR_WIDTH, 2, table address width; the table has 2**ADDR_WIDTH entries.
- DATA_WIDTH, 3, table word width.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  a request word is present on req_data.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_data  input  DATA_WIDTH  data word to search for.
- rsp_valid  output  1  a response is present; high only in RESP.
- rsp_ready  input  1  consumer accepts the response.
- rsp_hit  output  1  1 = word found; 0 = miss.
- rsp_addr  output  ADDR_WIDTH  address of the match; 0 on a miss.
- rsp_key  output  DATA_WIDTH  echo of the captured request word.

## Operation
- Fixed table contents, as address -> data:
  - 0 -> 3'b011
  - 1 -> 3'b110
  - 2 -> 3'b100
  - 3 -> 3'b010
- Expected lookups: 011 -> 0, 110 -> 1, 100 -> 2, 010 -> 3. The words 000, 001, 101 and 111 miss.
- If entries are ever duplicated, the lowest address wins.
- The FSM has three states: IDLE, SCAN and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture req_data into the key register, clear the index to 0, and go to SCAN.
- SCAN, one comparison per cycle against table[idx]:
  - On a match: set rsp_hit=1, set rsp_addr=idx, go to RESP.
  - On a mismatch with idx==2**ADDR_WIDTH-1: set rsp_hit=0, set rsp_addr=0, go to RESP.
  - Otherwise: idx <= idx+1, with no wrap-around.
- RESP:
  - rsp_valid=1, with rsp_hit, rsp_addr and rsp_key held stable.
  - On rsp_ready, go to IDLE.
- req_ready=0 throughout SCAN and RESP. Requests are not queued; req_data is sampled only at the handshake.
- All outputs come from registers or are decoded from state only. There is no combinational path from inputs to outputs.

## Timing
- Reset, asynchronous on rst_n low:
  - state=IDLE, idx=0.
  - rsp_valid=0, rsp_hit=0, rsp_addr=0, rsp_key=0.
  - req_ready=1 as soon as the block is in IDLE.
- Reset mid-operation, in SCAN or RESP: any pending response is discarded immediately and no rsp_valid appears after rst_n is released.
- Latency: let request acceptance happen at edge E0.
  - Hit at address k: rsp_valid rises after edge E(k+1), giving 1 to 4 cycles.
  - Miss: rsp_valid rises after edge E4.
- Backpressure: rsp_valid and all rsp_* signals stay stable until the cycle in which rsp_ready=1. The FSM leaves RESP on that edge.
- rsp_ready may be high before rsp_valid rises; the response then completes in its first valid cycle.
- Throughput:
  - req_ready returns to 1 in the cycle after the response handshake, so a new request can be accepted there.
  - Back-to-back minimum period is k+3 cycles per lookup.
- rsp_ready while rsp_valid=0 is ignored.
- req_valid outside IDLE is ignored. The producer must hold req_valid until it sees req_ready.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release. Required: rsp_valid=0, rsp_hit=0, rsp_addr=0, rsp_key=0, req_ready=1.
- Hits, with rsp_ready tied to 1, request each word:
  - 011 -> hit, addr 0, rsp_valid 1 cycle after acceptance.
  - 110 -> hit, addr 1, rsp_valid 2 cycles after acceptance.
  - 100 -> hit, addr 2, rsp_valid 3 cycles after acceptance.
  - 010 -> hit, addr 3, rsp_valid 4 cycles after acceptance.
- Misses: request each of 000, 001, 101 and 111. Required for each: rsp_hit=0, rsp_addr=0, rsp_key echoes the request, rsp_valid 4 cycles after acceptance.
- Backpressure: request 100 with rsp_ready=0 for 5 cycles, then 1. Required: rsp_valid held with hit=1, addr=2, key=100 for the full stall; req_ready=0 throughout; IDLE on the handshake edge.
- Reset mid-scan: request 010, then pull rst_n low 2 cycles after acceptance. Required: outputs cleared immediately and no response after release.
- Back-to-back stream of 011, 111, 110 with req_valid held high. Required:
  - Each request is accepted only when req_ready=1.
  - Responses arrive in order: (1,0), (0,0), (1,1).
  - No request is lost or duplicated.
